gb_cpu_alu_nibble: RTL and testbench

GB_CPU_ALU_NIBBLE -- requirements
Module: gb_cpu_alu_nibble

---
 rtl/gb_cpu_common_pkg.sv | 34 +++
 rtl/gb_cpu_alu_nibble_slice.sv | 38 +++
 rtl/gb_cpu_alu_nibble.sv | 179 +++++++++++++++++
 tb/tb_gb_cpu_alu_nibble.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared types for the nibble-serial ALU: flag bundle, opcode set, FSM states.
package gb_cpu_common_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_ADC = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SBC = 4'd4,
    ALU_CP  = 4'd5,
    ALU_AND = 4'd6,
    ALU_OR  = 4'd7,
    ALU_XOR = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ALU_ST_IDLE = 2'd0,
    ALU_ST_CALC = 2'd1,
    ALU_ST_DONE = 2'd2
  } alu_nibble_state_t;

  // Opcodes whose first nibble takes the incoming C flag as carry/borrow in.
  function automatic logic uses_carry_in(alu_op_t op);
    return (op == ALU_ADC) || (op == ALU_SBC);
  endfunction

endpackage

// File: rtl/gb_cpu_alu_nibble_slice.sv
// Four-bit ALU slice: one nibble of add/subtract/logic with true carry or borrow.
module gb_cpu_alu_nibble_slice
  import gb_cpu_common_pkg::*;
(
  input  alu_op_t    op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] y_o,
  output logic       cout_o
);

  logic [4:0] wide;

  // Compute the nibble result; subtraction reports borrow (not inverted carry) in bit 4.
  always_comb begin
    wide   = '0;
    y_o    = a_i;
    cout_o = 1'b0;
    case (op_i)
      ALU_ADD, ALU_ADC: begin
        wide   = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
        y_o    = wide[3:0];
        cout_o = wide[4];
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        wide   = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, cin_i};
        y_o    = wide[3:0];
        cout_o = wide[4];
      end
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/gb_cpu_alu_nibble.sv
// Nibble-serial ALU: accepts one request, computes one nibble per cycle LSB first,
// then holds the response until the consumer takes it.
module gb_cpu_alu_nibble
  import gb_cpu_common_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  alu_op_t               opcode_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  alu_flags_t            flags_i,
  input  logic                  keep_z_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output alu_flags_t            flags_o
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);
  localparam logic [1:0] H_IDX    = 2'(NIBBLES - 2);

  alu_nibble_state_t     state_q, state_d;
  alu_op_t               op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] sh_a_q, sh_a_d;
  logic [DATA_WIDTH-1:0] sh_b_q, sh_b_d;
  alu_flags_t            flags_in_q, flags_in_d;
  logic                  keep_z_q, keep_z_d;
  logic [1:0]            idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  h_q, h_d;
  logic [DATA_WIDTH-5:0] calc_q, calc_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  alu_flags_t            flags_q, flags_d;

  logic                  slice_cin;
  logic [3:0]            slice_y;
  logic                  slice_cout;
  logic [DATA_WIDTH-1:0] calc_full;
  logic                  z_final;

  // Nibble 0 takes the captured C only for the with-carry ops; later nibbles chain.
  assign slice_cin = (idx_q == 2'd0) ? (uses_carry_in(op_q) & flags_in_q.c) : carry_q;
  assign calc_full = {slice_y, calc_q};

  gb_cpu_alu_nibble_slice u_slice (
    .op_i   (op_q),
    .a_i    (sh_a_q[3:0]),
    .b_i    (sh_b_q[3:0]),
    .cin_i  (slice_cin),
    .y_o    (slice_y),
    .cout_o (slice_cout)
  );

  // Next-state and datapath: capture in IDLE, shift one nibble per CALC cycle,
  // resolve result and flags on the last nibble, hold in DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    sh_a_d     = sh_a_q;
    sh_b_d     = sh_b_q;
    flags_in_d = flags_in_q;
    keep_z_d   = keep_z_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    h_d        = h_q;
    calc_d     = calc_q;
    result_d   = result_q;
    flags_d    = flags_q;
    z_final    = keep_z_q ? flags_in_q.z : (calc_full == '0);
    case (state_q)
      ALU_ST_IDLE: begin
        if (req_valid_i) begin
          op_d       = opcode_i;
          a_d        = operand_a_i;
          sh_a_d     = operand_a_i;
          sh_b_d     = operand_b_i;
          flags_in_d = flags_i;
          keep_z_d   = keep_z_i;
          idx_d      = 2'd0;
          carry_d    = 1'b0;
          h_d        = 1'b0;
          calc_d     = '0;
          state_d    = ALU_ST_CALC;
        end
      end
      ALU_ST_CALC: begin
        sh_a_d  = sh_a_q >> 4;
        sh_b_d  = sh_b_q >> 4;
        calc_d  = calc_full[DATA_WIDTH-1:4];
        carry_d = slice_cout;
        idx_d   = idx_q + 2'd1;
        if (idx_q == H_IDX) begin
          h_d = slice_cout;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ALU_ST_DONE;
          case (op_q)
            ALU_ADD, ALU_ADC: begin
              result_d = calc_full;
              flags_d  = '{z: z_final, n: 1'b0, h: h_q, c: slice_cout};
            end
            ALU_SUB, ALU_SBC: begin
              result_d = calc_full;
              flags_d  = '{z: z_final, n: 1'b1, h: h_q, c: slice_cout};
            end
            ALU_CP: begin
              result_d = a_q;
              flags_d  = '{z: z_final, n: 1'b1, h: h_q, c: slice_cout};
            end
            ALU_AND: begin
              result_d = calc_full;
              flags_d  = '{z: z_final, n: 1'b0, h: 1'b1, c: 1'b0};
            end
            ALU_OR, ALU_XOR: begin
              result_d = calc_full;
              flags_d  = '{z: z_final, n: 1'b0, h: 1'b0, c: 1'b0};
            end
            default: begin
              result_d = a_q;
              flags_d  = flags_in_q;
            end
          endcase
        end
      end
      ALU_ST_DONE: begin
        if (rsp_ready_i) begin
          state_d = ALU_ST_IDLE;
        end
      end
      default: state_d = ALU_ST_IDLE;
    endcase
  end

  // Register update; reset aborts any operation in flight and clears the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ALU_ST_IDLE;
      op_q       <= ALU_NOP;
      a_q        <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      flags_in_q <= '0;
      keep_z_q   <= 1'b0;
      idx_q      <= 2'd0;
      carry_q    <= 1'b0;
      h_q        <= 1'b0;
      calc_q     <= '0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      flags_in_q <= flags_in_d;
      keep_z_q   <= keep_z_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      h_q        <= h_d;
      calc_q     <= calc_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign req_ready_o = (state_q == ALU_ST_IDLE);
  assign rsp_valid_o = (state_q == ALU_ST_DONE);
  assign result_o    = result_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_gb_cpu_alu_nibble.sv
// Bench for the nibble-serial ALU: directed vector table, randomized ops against a
// plain-arithmetic reference, and hand-written backpressure and reset-abort sequences.
module tb_gb_cpu_alu_nibble;
  import gb_cpu_common_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid8, req_valid16, rsp_ready8, rsp_ready16;
  logic       req_ready8, req_ready16, rsp_valid8, rsp_valid16;
  alu_op_t    opcode;
  logic [15:0] op_a, op_b;
  alu_flags_t flags_in;
  logic       keep_z;
  logic [7:0]  result8;
  logic [15:0] result16;
  alu_flags_t flags8, flags16;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    int         w;
    alu_op_t    op;
    logic [15:0] a;
    logic [15:0] b;
    alu_flags_t fi;
    logic       kz;
    logic [15:0] exp_res;
    alu_flags_t exp_f;
  } vec_t;

  vec_t vecs[$];

  gb_cpu_alu_nibble #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid8), .req_ready_o(req_ready8),
    .opcode_i(opcode), .operand_a_i(op_a[7:0]), .operand_b_i(op_b[7:0]),
    .flags_i(flags_in), .keep_z_i(keep_z),
    .rsp_valid_o(rsp_valid8), .rsp_ready_i(rsp_ready8),
    .result_o(result8), .flags_o(flags8)
  );

  gb_cpu_alu_nibble #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid16), .req_ready_o(req_ready16),
    .opcode_i(opcode), .operand_a_i(op_a), .operand_b_i(op_b),
    .flags_i(flags_in), .keep_z_i(keep_z),
    .rsp_valid_o(rsp_valid16), .rsp_ready_i(rsp_ready16),
    .result_o(result16), .flags_o(flags16)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: flags and result from whole-word arithmetic on the operands.
  function automatic logic [19:0] refModel(int w, alu_op_t op, logic [15:0] a, logic [15:0] b,
                                           alu_flags_t fi, logic kz);
    int mask, hmask, va, vb, cin, s, hs, res;
    logic z, n, h, c;
    mask  = (1 << w) - 1;
    hmask = (1 << (w - 4)) - 1;
    va = int'(a) & mask;
    vb = int'(b) & mask;
    cin = 0; s = 0; hs = 0; res = 0;
    z = 1'b0; n = 1'b0; h = 1'b0; c = 1'b0;
    case (op)
      ALU_ADD, ALU_ADC: begin
        cin = (op == ALU_ADC) ? int'(fi.c) : 0;
        s   = va + vb + cin;
        res = s & mask;
        c   = (s > mask);
        hs  = (va & hmask) + (vb & hmask) + cin;
        h   = (hs > hmask);
      end
      ALU_SUB, ALU_SBC, ALU_CP: begin
        cin = (op == ALU_SBC) ? int'(fi.c) : 0;
        s   = va - vb - cin;
        res = s & mask;
        c   = (s < 0);
        hs  = (va & hmask) - (vb & hmask) - cin;
        h   = (hs < 0);
        n   = 1'b1;
      end
      ALU_AND: begin res = va & vb; h = 1'b1; end
      ALU_OR:  res = va | vb;
      ALU_XOR: res = va ^ vb;
      default: return {16'(va), fi};
    endcase
    z = kz ? fi.z : (res == 0);
    if (op == ALU_CP) res = va;
    return {16'(res), z, n, h, c};
  endfunction

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request to the selected DUT, scramble inputs after acceptance,
  // and count edges until the response appears (bounded).
  task automatic applyStimulus(input int w, input alu_op_t op, input logic [15:0] a,
                               input logic [15:0] b, input alu_flags_t fi, input logic kz,
                               output int lat);
    @(negedge clk);
    opcode = op; op_a = a; op_b = b; flags_in = fi; keep_z = kz;
    checkOutput("ready_before_accept", {15'd0, (w == 8) ? req_ready8 : req_ready16}, 16'd1);
    if (w == 8) req_valid8 = 1'b1; else req_valid16 = 1'b1;
    @(posedge clk); #1;
    req_valid8 = 1'b0; req_valid16 = 1'b0;
    opcode   = alu_op_t'(4'($urandom_range(0, 15)));
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    flags_in = alu_flags_t'(4'($urandom));
    keep_z   = 1'($urandom);
    lat = 0;
    while (!((w == 8) ? rsp_valid8 : rsp_valid16) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Hand the response to the consumer for one cycle.
  task automatic releaseRsp(input int w);
    @(negedge clk);
    if (w == 8) rsp_ready8 = 1'b1; else rsp_ready16 = 1'b1;
    @(posedge clk); #1;
    rsp_ready8 = 1'b0; rsp_ready16 = 1'b0;
  endtask

  // Run one operation end to end and check latency, result and flags.
  task automatic runAndCheck(input string name, input int w, input alu_op_t op,
                             input logic [15:0] a, input logic [15:0] b, input alu_flags_t fi,
                             input logic kz, input logic [15:0] exp_res, input alu_flags_t exp_f);
    int lat;
    logic [15:0] res;
    alu_flags_t  fo;
    applyStimulus(w, op, a, b, fi, kz, lat);
    res = (w == 8) ? {8'd0, result8} : result16;
    fo  = (w == 8) ? flags8 : flags16;
    checkOutput($sformatf("%s_latency", name), 16'(lat), 16'(w / 4));
    checkOutput($sformatf("%s_result", name), res, exp_res);
    checkOutput($sformatf("%s_flags", name), {12'd0, fo}, {12'd0, exp_f});
    releaseRsp(w);
  endtask

  initial begin
    int          lat;
    logic [19:0] exp;
    logic [15:0] hold_res;
    alu_flags_t  hold_f;
    int          w;
    alu_op_t     op;
    logic [15:0] a, b;
    alu_flags_t  fi;
    logic        kz;

    reset = 1'b1;
    req_valid8 = 1'b0; req_valid16 = 1'b0; rsp_ready8 = 1'b0; rsp_ready16 = 1'b0;
    opcode = ALU_NOP; op_a = '0; op_b = '0; flags_in = '0; keep_z = 1'b0;

    vecs.push_back('{"add_3a_c6",   8,  ALU_ADD, 16'h003A, 16'h00C6, 4'b0000, 1'b0, 16'h0000, 4'b1011});
    vecs.push_back('{"sbc_10_01",   8,  ALU_SBC, 16'h0010, 16'h0001, 4'b0001, 1'b0, 16'h000E, 4'b0110});
    vecs.push_back('{"add16_keepz", 16, ALU_ADD, 16'h0FFF, 16'h0001, 4'b0000, 1'b1, 16'h1000, 4'b0010});
    vecs.push_back('{"cp_42_42",    8,  ALU_CP,  16'h0042, 16'h0042, 4'b0000, 1'b0, 16'h0042, 4'b1100});
    vecs.push_back('{"add_ff_01",   8,  ALU_ADD, 16'h00FF, 16'h0001, 4'b0000, 1'b0, 16'h0000, 4'b1011});
    vecs.push_back('{"sub_00_01",   8,  ALU_SUB, 16'h0000, 16'h0001, 4'b0000, 1'b0, 16'h00FF, 4'b0111});
    vecs.push_back('{"and_f0_0f",   8,  ALU_AND, 16'h00F0, 16'h000F, 4'b0000, 1'b0, 16'h0000, 4'b1010});
    vecs.push_back('{"nop8",        8,  ALU_NOP, 16'h0055, 16'h00AA, 4'b1010, 1'b0, 16'h0055, 4'b1010});
    vecs.push_back('{"unsup16",     16, alu_op_t'(4'd13), 16'h1234, 16'h4321, 4'b0101, 1'b0, 16'h1234, 4'b0101});
    vecs.push_back('{"sbc16_0_0",   16, ALU_SBC, 16'h0000, 16'h0000, 4'b0001, 1'b0, 16'hFFFF, 4'b0111});
    vecs.push_back('{"xor_keepz",   8,  ALU_XOR, 16'h005A, 16'h005A, 4'b0011, 1'b1, 16'h0000, 4'b0000});
    vecs.push_back('{"adc16_wrap",  16, ALU_ADC, 16'h8000, 16'h8000, 4'b0001, 1'b0, 16'h0001, 4'b0001});
    vecs.push_back('{"or_zero",     8,  ALU_OR,  16'h0000, 16'h0000, 4'b0100, 1'b0, 16'h0000, 4'b1000});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready8",  {15'd0, req_ready8},  16'd1);
    checkOutput("reset_valid8",  {15'd0, rsp_valid8},  16'd0);
    checkOutput("reset_result8", {8'd0, result8},      16'd0);
    checkOutput("reset_flags16", {12'd0, flags16},     16'd0);
    checkOutput("reset_valid16", {15'd0, rsp_valid16}, 16'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      runAndCheck(vecs[i].name, vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].fi, vecs[i].kz, vecs[i].exp_res, vecs[i].exp_f);
    end

    for (int i = 0; i < 200; i++) begin
      w  = ($urandom_range(0, 1) == 0) ? 8 : 16;
      op = alu_op_t'(4'($urandom_range(0, 15)));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (w == 8) begin a[15:8] = 8'd0; b[15:8] = 8'd0; end
      fi = alu_flags_t'(4'($urandom));
      kz = ($urandom_range(0, 3) == 0);
      exp = refModel(w, op, a, b, fi, kz);
      runAndCheck($sformatf("rand%0d", i), w, op, a, b, fi, kz, exp[19:4], alu_flags_t'(exp[3:0]));
    end

    // Backpressure: response held while a competing request waits.
    exp = refModel(8, ALU_SUB, 16'h0023, 16'h0034, 4'b0000, 1'b0);
    applyStimulus(8, ALU_SUB, 16'h0023, 16'h0034, 4'b0000, 1'b0, lat);
    hold_res = {8'd0, result8};
    hold_f   = flags8;
    checkOutput("hold_first_result", hold_res, exp[19:4]);
    @(negedge clk);
    opcode = ALU_ADD; op_a = 16'h0099; op_b = 16'h0011; req_valid8 = 1'b1; rsp_ready8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid",  {15'd0, rsp_valid8}, 16'd1);
      checkOutput("hold_ready",  {15'd0, req_ready8}, 16'd0);
      checkOutput("hold_result", {8'd0, result8},     exp[19:4]);
      checkOutput("hold_flags",  {12'd0, flags8},     {12'd0, exp[3:0]});
    end
    @(negedge clk);
    rsp_ready8 = 1'b1;
    @(posedge clk); #1;
    rsp_ready8 = 1'b0;
    req_valid8 = 1'b0;
    checkOutput("release_valid", {15'd0, rsp_valid8}, 16'd0);
    checkOutput("release_ready", {15'd0, req_ready8}, 16'd1);
    @(posedge clk); #1;
    checkOutput("not_taken_ready", {15'd0, req_ready8}, 16'd1);
    checkOutput("not_taken_valid", {15'd0, rsp_valid8}, 16'd0);

    // Reset during the second compute cycle of a 16-bit operation.
    @(negedge clk);
    opcode = ALU_ADD; op_a = 16'h1234; op_b = 16'h4321; flags_in = 4'b1111; keep_z = 1'b0;
    req_valid16 = 1'b1;
    @(posedge clk); #1;
    req_valid16 = 1'b0;
    checkOutput("abort_in_calc", {15'd0, req_ready16}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_ready",  {15'd0, req_ready16}, 16'd1);
    checkOutput("abort_valid",  {15'd0, rsp_valid16}, 16'd0);
    checkOutput("abort_result", result16,             16'd0);
    checkOutput("abort_flags",  {12'd0, flags16},     16'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_rsp", {15'd0, rsp_valid16}, 16'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
